// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//
// Receive-side monitor for a two-digit, time-multiplexed seven-segment bus.
// Each bus phase ({digit_sel_in, segment_in}) must hold for SETTLE identical
// samples before it is captured. A high-digit capture followed by a
// low-digit capture forms a frame. The frame is published as raw glyphs and
// as decoded hex nibbles, together with per-digit legality flags. A watchdog
// flags the bus as stale when no phase has been captured for TIMEOUT cycles.
//
// Parameters
//   SETTLE   consecutive identical samples needed to capture (2..15)
//   TIMEOUT  cycles without a capture before stale is raised
//   TBITS    watchdog width, TIMEOUT < 2**TBITS
//
// Ports
//   clk            clock
//   rst            synchronous, active-high reset
//   segment_in     glyph bits {g,f,e,d,c,b,a}, active-high
//   digit_sel_in   1 = high digit on the bus, 0 = low digit
//   both7seg_out   {hi glyph, lo glyph} of the last complete frame
//   hex_out        {hi nibble, lo nibble} decoded from both7seg_out
//   hex_ok         bit1 = hi glyph legal, bit0 = lo glyph legal
//   frame_valid    one-cycle pulse when a new frame is published
//   stale          high while no capture has occurred for TIMEOUT cycles

module seven_seg_capture #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 30000,
  parameter int TBITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment_in,
  input  logic        digit_sel_in,
  output logic [13:0] both7seg_out,
  output logic [7:0]  hex_out,
  output logic [1:0]  hex_ok,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [3:0]       SETTLE_C  = 4'(SETTLE);
  localparam logic [TBITS-1:0] TIMEOUT_C = TBITS'(TIMEOUT);

  typedef enum logic {
    EXPECT_HI = 1'b0,
    EXPECT_LO = 1'b1
  } state_e;

  // Glyph-to-nibble decode. Result is {legal, nibble}; illegal glyphs
  // (including blank) decode to nibble 0 with legal cleared.
  function automatic logic [4:0] decode_glyph(input logic [6:0] glyph);
    logic [4:0] res;
    case (glyph)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  // Saturating increment of the 4-bit run counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  // Registers and next-state values
  state_e           state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic [TBITS-1:0] wd_q, wd_d;
  logic [6:0]       hi_buf_q, hi_buf_d;
  logic [6:0]       lo_buf_q, lo_buf_d;
  logic [13:0]      both_q, both_d;
  logic [7:0]       hex_q, hex_d;
  logic [1:0]       ok_q, ok_d;
  logic             fv_q, fv_d;
  logic             stale_q, stale_d;

  // Combinational helpers
  logic [7:0]       sample;
  logic             same;
  logic             capture;
  logic             timeout;
  logic [TBITS-1:0] wd_inc;
  logic [4:0]       dec_hi;
  logic [4:0]       dec_lo;

  assign sample = {digit_sel_in, segment_in};
  assign same   = (sample == prev_q);

  // Run-length tracking. The counter saturates at 15, so with SETTLE=15 the
  // run would sit at SETTLE forever; the extra term makes the capture fire
  // only on the edge where the run actually steps onto SETTLE.
  always_comb begin
    run_d   = same ? sat_inc4(run_q) : 4'd1;
    prev_d  = sample;
    capture = (run_d == SETTLE_C) && !(same && (run_q == SETTLE_C));
  end

  // Watchdog: clears on any capture, otherwise counts up to TIMEOUT and
  // holds. A capture on the same edge as the timeout takes priority.
  always_comb begin
    wd_inc  = (wd_q == TIMEOUT_C) ? wd_q : wd_q + TBITS'(1);
    wd_d    = capture ? '0 : wd_inc;
    timeout = !capture && (wd_inc == TIMEOUT_C);
  end

  assign dec_hi = decode_glyph(hi_buf_q);
  assign dec_lo = decode_glyph(segment_in);

  // Frame FSM and publish logic
  always_comb begin
    state_d  = state_q;
    hi_buf_d = hi_buf_q;
    lo_buf_d = lo_buf_q;
    both_d   = both_q;
    hex_d    = hex_q;
    ok_d     = ok_q;
    fv_d     = 1'b0;
    stale_d  = stale_q;

    if (capture) begin
      case (state_q)
        EXPECT_HI: begin
          // A low-digit capture here is the tail of a frame we never saw
          // the start of, so it is dropped.
          if (digit_sel_in) begin
            hi_buf_d = segment_in;
            state_d  = EXPECT_LO;
          end
        end
        EXPECT_LO: begin
          if (digit_sel_in) begin
            // A fresh high phase replaces the pending one.
            hi_buf_d = segment_in;
          end else begin
            lo_buf_d = segment_in;
            both_d   = {hi_buf_q, segment_in};
            hex_d    = {dec_hi[3:0], dec_lo[3:0]};
            ok_d     = {dec_hi[4], dec_lo[4]};
            fv_d     = 1'b1;
            stale_d  = 1'b0;
            state_d  = EXPECT_HI;
          end
        end
        default: state_d = EXPECT_HI;
      endcase
    end else if (timeout) begin
      // Published outputs keep the last frame; only the flag changes and
      // any half-received frame is abandoned.
      stale_d = 1'b1;
      state_d = EXPECT_HI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EXPECT_HI;
      prev_q   <= '0;
      run_q    <= '0;
      wd_q     <= '0;
      hi_buf_q <= '0;
      lo_buf_q <= '0;
      both_q   <= '0;
      hex_q    <= '0;
      ok_q     <= '0;
      fv_q     <= 1'b0;
      stale_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      run_q    <= run_d;
      wd_q     <= wd_d;
      hi_buf_q <= hi_buf_d;
      lo_buf_q <= lo_buf_d;
      both_q   <= both_d;
      hex_q    <= hex_d;
      ok_q     <= ok_d;
      fv_q     <= fv_d;
      stale_q  <= stale_d;
    end
  end

  assign both7seg_out = both_q;
  assign hex_out      = hex_q;
  assign hex_ok       = ok_q;
  assign frame_valid  = fv_q;
  assign stale        = stale_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed testbench for seven_seg_capture (SETTLE=4, short TIMEOUT).

module tb_seven_seg_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 40;
  localparam int TBITS   = 8;

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic        sel;
  logic [13:0] both7seg_out;
  logic [7:0]  hex_out;
  logic [1:0]  hex_ok;
  logic        frame_valid;
  logic        stale;

  int n_checks = 0;
  int n_errors = 0;
  int fv_cnt   = 0;
  int fv_base;

  seven_seg_capture #(
    .SETTLE (SETTLE),
    .TIMEOUT(TIMEOUT),
    .TBITS  (TBITS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .segment_in  (seg),
    .digit_sel_in(sel),
    .both7seg_out(both7seg_out),
    .hex_out     (hex_out),
    .hex_ok      (hex_ok),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid pulses, sampled mid-cycle.
  always @(negedge clk) if (frame_valid === 1'b1) fv_cnt = fv_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic s, input logic [6:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".both"},  32'(both7seg_out), 32'h0);
    check({tag, ".hex"},   32'(hex_out),      32'h0);
    check({tag, ".ok"},    32'(hex_ok),       32'h0);
    check({tag, ".fv"},    32'(frame_valid),  32'h0);
    check({tag, ".stale"}, 32'(stale),        32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "testbench time limit");
  end

  initial begin
    rst = 1'b1;
    sel = 1'b0;
    seg = 7'h00;
    step();
    step();
    rst = 1'b0;
    check_outputs_zero("reset");

    // Clean frame: hi 0x06, lo 0x5B, publish on the 4th lo sample.
    hold(1'b1, 7'h06, 10);
    fv_base = fv_cnt;
    hold(1'b0, 7'h5B, 3);
    check("clean.fv_early", 32'(frame_valid), 32'h0);
    step();
    check("clean.fv",    32'(frame_valid),  32'h1);
    check("clean.both",  32'(both7seg_out), 32'({7'h06, 7'h5B}));
    check("clean.hex",   32'(hex_out),      32'h12);
    check("clean.ok",    32'(hex_ok),       32'h3);
    step();
    check("clean.fv_drop", 32'(frame_valid), 32'h0);
    repeat (4) step();
    check("clean.pulses", 32'(fv_cnt - fv_base), 32'h1);

    // Glitch during the stable lo phase, then re-settle on 0x5B.
    fv_base = fv_cnt;
    hold(1'b0, 7'h7F, 2);
    hold(1'b0, 7'h5B, 10);
    check("glitch.pulses", 32'(fv_cnt - fv_base), 32'h0);
    check("glitch.both",   32'(both7seg_out), 32'({7'h06, 7'h5B}));
    check("glitch.hex",    32'(hex_out),      32'h12);

    // Illegal (blank) hi glyph with a legal lo glyph.
    fv_base = fv_cnt;
    hold(1'b1, 7'h00, 10);
    hold(1'b0, 7'h71, 10);
    check("illegal.pulses", 32'(fv_cnt - fv_base), 32'h1);
    check("illegal.both",   32'(both7seg_out), 32'h0071);
    check("illegal.hex",    32'(hex_out),      32'h0F);
    check("illegal.ok",     32'(hex_ok),       32'h1);

    // Stale: publish a frame, then freeze the bus.
    hold(1'b1, 7'h7F, 10);
    hold(1'b0, 7'h6F, 4);   // last capture happens on this 4th edge
    check("stale.fv",   32'(frame_valid), 32'h1);
    check("stale.hex",  32'(hex_out),     32'h89);
    repeat (TIMEOUT - 1) step();
    check("stale.early", 32'(stale), 32'h0);
    step();
    check("stale.rise", 32'(stale),        32'h1);
    check("stale.both", 32'(both7seg_out), 32'({7'h7F, 7'h6F}));
    check("stale.hex2", 32'(hex_out),      32'h89);
    check("stale.ok",   32'(hex_ok),       32'h3);
    repeat (5) step();
    check("stale.hold", 32'(stale), 32'h1);
    hold(1'b1, 7'h77, 10);
    check("stale.after_hi", 32'(stale), 32'h1);
    hold(1'b0, 7'h7C, 3);
    check("stale.before_pub", 32'(stale), 32'h1);
    step();
    check("stale.clear",  32'(stale),       32'h0);
    check("stale.fv_new", 32'(frame_valid), 32'h1);
    check("stale.hex_new", 32'(hex_out),    32'hAB);
    repeat (6) step();

    // Out-of-order start: lo, hi, lo gives exactly one frame.
    fv_base = fv_cnt;
    hold(1'b0, 7'h3F, 10);
    check("ooo.first_lo", 32'(fv_cnt - fv_base), 32'h0);
    hold(1'b1, 7'h4F, 10);
    hold(1'b0, 7'h66, 10);
    check("ooo.pulses", 32'(fv_cnt - fv_base), 32'h1);
    check("ooo.hex",    32'(hex_out),      32'h34);
    check("ooo.both",   32'(both7seg_out), 32'({7'h4F, 7'h66}));

    // Reset between hi capture and lo capture.
    hold(1'b1, 7'h5E, 10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_outputs_zero("midrst");
    fv_base = fv_cnt;
    hold(1'b0, 7'h79, 10);
    check("midrst.lo_only", 32'(fv_cnt - fv_base), 32'h0);
    check("midrst.both",    32'(both7seg_out), 32'h0);

    // Recovery with a full frame afterwards.
    hold(1'b1, 7'h5E, 10);
    hold(1'b0, 7'h79, 4);
    check("recover.fv",  32'(frame_valid), 32'h1);
    check("recover.hex", 32'(hex_out),     32'hDE);
    check("recover.ok",  32'(hex_ok),      32'h3);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side companion to the two-digit seven-segment multiplexer. It watches the time-multiplexed `segment`/`digit_select` bus, waits for each phase to settle, and reassembles the 14-bit two-digit pattern. It also decodes both glyphs back to hex nibbles. It sits on the display-bus monitor path for loopback self-test and for formal round-trip checks against the transmitter.

## Interface
- `SETTLE`, default 4: consecutive identical samples required before a phase is captured (legal range 2..15).
- `TIMEOUT`, default 30000: cycles without a capture before the bus is declared stale.
- `TBITS`, default 16: watchdog counter width; must satisfy TIMEOUT < 2^TBITS.
- `clk`  in  1: clock.
- `rst`  in  1: reset; synchronous, active-high.
- `segment_in`  in  7: glyph bits `{g,f,e,d,c,b,a}`, active-high.
- `digit_sel_in`  in  1: 1 = high digit on bus, 0 = low digit.
- `both7seg_out`  out  14: `{hi glyph, lo glyph}` of the last complete frame.
- `hex_out`  out  8: `{hi nibble, lo nibble}` decoded from `both7seg_out`.
- `hex_ok`  out  2: bit1 = hi glyph legal, bit0 = lo glyph legal.
- `frame_valid`  out  1: one-cycle pulse when new frame outputs are published.
- `stale`  out  1: high while no capture has occurred for TIMEOUT cycles.

## Operation
- **Run-length tracking.**
  - Registers: `prev` (8 bits, `{sel,seg}`) and `run` (4 bits, saturating).
  - Each edge: `run <= ({digit_sel_in,segment_in}==prev) ? sat(run+1) : 1`, then `prev <=` the inputs.
  - A capture fires on the edge where the new `run` equals exactly SETTLE. It therefore fires once per stable phase.
- **Frame FSM**, two states:
  - EXPECT_HI: a capture with sel=1 loads `hi_buf` and moves to EXPECT_LO. A capture with sel=0 is ignored.
  - EXPECT_LO: a capture with sel=0 loads `lo_buf` and publishes. A capture with sel=1 reloads `hi_buf` and stays in EXPECT_LO.
- **Publish**, all in one edge:
  - `both7seg_out <= {hi_buf, seg}`.
  - `hex_out` and `hex_ok` are updated from the decode of the same values.
  - `frame_valid <= 1` for one cycle.
  - `stale <= 0`.
  - FSM goes to EXPECT_HI.
- **Decode table** (glyph → nibble):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7.
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F.
  - Any other glyph, including blank 0x00, gives nibble 0 with its `hex_ok` bit 0.
  - `both7seg_out` still carries the raw glyph in that case.
- **Watchdog.**
  - `wd` is TBITS wide. It clears on every capture and otherwise increments, saturating at TIMEOUT.
  - When `wd` reaches TIMEOUT: `stale <= 1` and FSM forced to EXPECT_HI. The outputs keep the last frame.
  - A capture and the timeout on the same edge: the capture wins, `wd` clears and `stale` is unchanged.
- **Reset** (any cycle, including mid-phase or mid-frame): clears `prev`, `run`, `wd`, `hi_buf` and `lo_buf`; FSM to EXPECT_HI; all outputs to 0.

## Timing
- Reset values: `both7seg_out`=0, `hex_out`=0, `hex_ok`=0, `frame_valid`=0, `stale`=0.
- The inputs change before edge e0, and samples at e0..e(SETTLE-1) are identical. The capture is then on edge e(SETTLE-1).
- A lo capture on edge eN makes `frame_valid`, `both7seg_out`, `hex_out` and `hex_ok` visible after eN. `frame_valid` deasserts after eN+1.
- The published outputs are registered and change only on the publish edge, never partially.
- Glitches shorter than SETTLE samples are never captured. A phase held for fewer than SETTLE cycles is lost, and the frame waits for the next legal hi→lo pair.
- `stale` rises on the edge where `wd` reaches TIMEOUT, i.e. TIMEOUT cycles after the last capture with no intervening capture.

## Test plan
- **Clean frame.** Reset, then drive sel=1/seg=0x06 for 10 cycles, then sel=0/seg=0x5B for 10 cycles. Required: exactly one `frame_valid` pulse, 4 cycles after the lo phase starts (SETTLE=4), with `both7seg_out`=0x035B, `hex_out`=0x12, `hex_ok`=2'b11.
- **Glitch rejection.** During a stable lo phase, insert a 2-cycle seg=0x7F blip. Required: no extra capture and no `frame_valid`. Re-stabilising at the original 0x5B causes a new capture; in EXPECT_HI it is ignored.
- **Illegal glyph.** hi=0x00, lo=0x71. Required: `both7seg_out`=0x0071, `hex_out`=0x0F, `hex_ok`=2'b01.
- **Stale.** After one good frame, freeze the inputs. Required: `stale`=1 exactly TIMEOUT cycles after the last capture, with the outputs unchanged. The next full hi→lo frame clears `stale` on its publish edge.
- **Out-of-order start.** The bus begins in the lo phase (sel=0, 0x3F), then hi (0x4F), then lo (0x66). Required: the first lo is ignored and exactly one frame is published, `hex_out`=0x34.
- **Reset mid-frame.** Assert `rst` for 1 cycle after the hi capture but before the lo capture. Required: all outputs 0. The subsequent lo phase alone produces no `frame_valid`.
